// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler: frame-level sequencer for the decimation-in-time FFT.
// Launches log2(N) butterfly stages one at a time, drains the butterfly
// pipeline between stages and flags frame completion to the unloader.
// Optional watchdog on the RUN wait: define FFT_SCHED_WDOG_EN.
module fft_stage_scheduler #(
    parameter int N        = 16,
    parameter int SIZE     = 4,
    parameter int PIPE_LAT = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            load_done,
    input  logic            stage_done,
    output logic            start_stage,
    output logic [SIZE-1:0] stage,
    output logic [SIZE-1:0] tw_shift,
    output logic            bank_sel,
    output logic            busy,
    output logic            frame_done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_LAUNCH, S_RUN, S_DRAIN, S_DONE
    } state_t;

    // Index of the final stage; SIZE and log2(N) coincide for legal configs.
    localparam logic [SIZE-1:0] LAST_STAGE = SIZE'($clog2(N) - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       advance;
    logic       wd_fire;

    // Advance step: stage completion with no pipeline to drain, or drain finished.
    assign advance = ((state == S_RUN) && stage_done && (PIPE_LAT == 0)) ||
                     ((state == S_DRAIN) && (drain_cnt == 4'd0));

`ifdef FFT_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Fires on the TIMEOUT-th RUN cycle without a stage completion.
    assign wd_fire = (state == S_RUN) && !stage_done && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog counter (restarts each LAUNCH) and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                wd_cnt <= '0;
            else if (state == S_RUN)
                wd_cnt <= wd_cnt + WD_W'(1);
            if (state == S_IDLE && start)
                err <= 1'b0;
            else if (wd_fire)
                err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    // Main sequencer; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            start_stage <= 1'b0;
            stage       <= '0;
            tw_shift    <= LAST_STAGE;
            bank_sel    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            drain_cnt   <= 4'd0;
        end else begin
            start_stage <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_WAIT_LOAD;
                        busy     <= 1'b1;
                        stage    <= '0;
                        tw_shift <= LAST_STAGE;
                        bank_sel <= 1'b0;
                    end
                end
                S_WAIT_LOAD: begin
                    if (load_done) begin
                        state       <= S_LAUNCH;
                        start_stage <= 1'b1;
                    end
                end
                S_LAUNCH: state <= S_RUN;
                S_RUN: begin
                    if (wd_fire) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (stage_done && (PIPE_LAT > 0)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 4'(PIPE_LAT - 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 4'd0)
                        drain_cnt <= drain_cnt - 4'd1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Stage index saturates at the last stage; the frame ends there.
            if (advance) begin
                if (stage == LAST_STAGE) begin
                    state      <= S_DONE;
                    frame_done <= 1'b1;
                end else begin
                    state       <= S_LAUNCH;
                    start_stage <= 1'b1;
                    stage       <= stage + SIZE'(1);
                    tw_shift    <= tw_shift - SIZE'(1);
                    bank_sel    <= ~bank_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: PIPE_LAT=3 instance for the main
// frame, stall, spurious-input, reset and watchdog scenarios; PIPE_LAT=0
// instance for back-to-back launches.
module tb_fft_stage_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0, load_done, stage_done, stage_done0;
    logic       start_stage, bank_sel, busy, frame_done, err;
    logic [3:0] stage, tw_shift;
    logic       start_stage0, bank_sel0, busy0, frame_done0, err0;
    logic [3:0] stage0, tw_shift0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_stage_scheduler #(.N(16), .SIZE(4), .PIPE_LAT(3), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .load_done(load_done),
        .stage_done(stage_done), .start_stage(start_stage), .stage(stage),
        .tw_shift(tw_shift), .bank_sel(bank_sel), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    fft_stage_scheduler #(.N(16), .SIZE(4), .PIPE_LAT(0), .TIMEOUT(64)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .load_done(load_done),
        .stage_done(stage_done0), .start_stage(start_stage0), .stage(stage0),
        .tw_shift(tw_shift0), .bank_sel(bank_sel0), .busy(busy0),
        .frame_done(frame_done0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 4-stage frame, stage_done 8 cycles after each launch. With sp set,
    // extra start/stage_done pulses land in IDLE, LAUNCH, RUN, DRAIN and DONE.
    task automatic run_frame(input bit sp);
        int k;
        load_done = 1'b1;
        for (int c = 0; c < 54; c++) begin
            start      = (c == 0) || (sp && (c == 5 || c == 12 || c == 50));
            stage_done = (c == 10 || c == 22 || c == 34 || c == 46) ||
                         (sp && (c == 0 || c == 2 || c == 12 || c == 50));
            chk("start_stage", start_stage, (c == 2 || c == 14 || c == 26 || c == 38));
            chk("frame_done", frame_done, (c == 50));
            chk("busy", busy, (c >= 1 && c <= 50));
            chk("err", err, 0);
            if (c == 2 || c == 14 || c == 26 || c == 38) begin
                k = (c - 2) / 12;
                chk("stage", stage, k);
                chk("tw_shift", tw_shift, 3 - k);
                chk("bank_sel", bank_sel, k % 2);
            end
            if (c == 50) chk("stage_in_done", stage, 3);
            step();
        end
        start      = 1'b0;
        stage_done = 1'b0;
        chk("stage_kept", stage, 3);
        chk("tw_kept", tw_shift, 0);
        chk("bank_kept", bank_sel, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start0 = 1'b0; load_done = 1'b0;
        stage_done = 1'b0; stage_done0 = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_stage", stage, 0);
        chk("rst_tw", tw_shift, 3);
        chk("rst_bank", bank_sel, 0);
        chk("rst_ss", start_stage, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Nominal frame
        run_frame(1'b0);

        // load_done stall, then reset during the second RUN
        for (int c = 0; c < 34; c++) begin
            start      = (c == 0);
            load_done  = (c >= 20);
            stage_done = (c == 25);
            rst        = (c == 32);
            if (c <= 32) begin
                chk("stall_ss", start_stage, (c == 21 || c == 29));
                chk("stall_busy", busy, (c >= 1));
                chk("stall_fd", frame_done, 0);
            end
            if (c == 21) begin
                chk("restart_stage", stage, 0);
                chk("restart_tw", tw_shift, 3);
                chk("restart_bank", bank_sel, 0);
            end
            if (c == 29) begin
                chk("s1_stage", stage, 1);
                chk("s1_tw", tw_shift, 2);
                chk("s1_bank", bank_sel, 1);
            end
            if (c == 33) begin
                chk("abort_busy", busy, 0);
                chk("abort_stage", stage, 0);
                chk("abort_tw", tw_shift, 3);
                chk("abort_bank", bank_sel, 0);
                chk("abort_ss", start_stage, 0);
                chk("abort_fd", frame_done, 0);
                chk("abort_err", err, 0);
                rst = 1'b0;
            end
            if (c < 33) step();
        end
        start = 1'b0; stage_done = 1'b0;
        step();

        // Frame with spurious start/stage_done pulses
        run_frame(1'b1);

        // Zero-latency pipeline: launch every other cycle
        load_done = 1'b1;
        for (int c = 0; c < 13; c++) begin
            start0      = (c == 0);
            stage_done0 = (c == 3 || c == 5 || c == 7 || c == 9);
            chk("p0_ss", start_stage0, (c == 2 || c == 4 || c == 6 || c == 8));
            chk("p0_fd", frame_done0, (c == 10));
            chk("p0_busy", busy0, (c >= 1 && c <= 10));
            if (c == 2 || c == 4 || c == 6 || c == 8) chk("p0_stage", stage0, (c - 2) / 2);
            step();
        end
        start0 = 1'b0; stage_done0 = 1'b0;

        // stage_done withheld in stage 1
        for (int c = 0; c < 87; c++) begin
            start      = (c == 0 || c == 85);
            stage_done = (c == 10);
            chk("wd_ss", start_stage, (c == 2 || c == 14));
            chk("wd_fd", frame_done, 0);
`ifdef FFT_SCHED_WDOG_EN
            chk("wd_busy", busy, ((c >= 1 && c <= 78) || c == 86));
            chk("wd_err", err, (c >= 79 && c <= 85));
`else
            chk("wd_busy", busy, (c >= 1));
            chk("wd_err", err, 0);
`endif
            step();
        end
        start = 1'b0; stage_done = 1'b0;
        rst = 1'b1;
        step();
        chk("final_busy", busy, 0);
        chk("final_err", err, 0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_scheduler.md
# fft_stage_scheduler

Frame-level sequencer for the parallel time-decimation FFT. It waits for the input buffer to be loaded, then launches the log2(N) butterfly stages one at a time. For each stage it pulses the per-stage address generators' `start_stage` and waits for their completion. It then drains the butterfly pipeline before the next stage. Per stage it drives the stage index, the twiddle shift and the ping-pong bank select, and it signals frame completion to the output unloader.

## Interface
- `N`, 16: FFT length, power of two, ≥4.
- `SIZE`, 4: log2(N); also the number of stages.
- `PIPE_LAT`, 3: butterfly/RAM write-back latency in cycles, 0..15.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `FFT_SCHED_WDOG_EN`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `start`  in  1: frame request, sampled in IDLE only.
- `load_done`  in  1: level; input buffer holds a complete frame.
- `stage_done`  in  1: one-cycle pulse from the address generators when a stage's reads are finished.
- `start_stage`  out  1: one-cycle launch pulse to the address generators.
- `stage`  out  SIZE: current stage index, 0..SIZE-1.
- `tw_shift`  out  SIZE: twiddle index shift, equal to SIZE-1-stage.
- `bank_sel`  out  1: ping-pong select. 0 means read bank A and write bank B.
- `busy`  out  1: high in every state except IDLE.
- `frame_done`  out  1: one-cycle pulse when the frame ends.
- `err`  out  1: watchdog flag. Tied 0 without `FFT_SCHED_WDOG_EN`.

## Operation
- States: IDLE, WAIT_LOAD, LAUNCH, RUN, DRAIN, DONE. State is registered. All outputs are registered or decoded from state only.
- Reset values (every output): state IDLE, `start_stage` 0, `stage` 0, `tw_shift` SIZE-1, `bank_sel` 0, `busy` 0, `frame_done` 0, `err` 0. Drain and watchdog counters are also 0.
- IDLE: `start`=1 → WAIT_LOAD. `stage` is cleared to 0 and `bank_sel` to 0.
- WAIT_LOAD: `load_done`=1 → LAUNCH.
- LAUNCH: lasts exactly 1 cycle with `start_stage`=1, then RUN.
- RUN: waits for `stage_done`.
  - If `stage_done` arrives and PIPE_LAT>0 → DRAIN. The drain counter loads PIPE_LAT-1.
  - If `stage_done` arrives and PIPE_LAT=0 → go directly to the advance step.
- DRAIN: counts down to 0, then performs the advance step.
- Advance step:
  - If `stage`==SIZE-1 → DONE.
  - Otherwise → LAUNCH with `stage`+1, `tw_shift`-1, and `bank_sel` toggled.
- DONE: lasts 1 cycle with `frame_done`=1, then IDLE. `stage`, `tw_shift` and `bank_sel` keep their last-stage values until the next `start`.
- Ignored inputs:
  - `start` outside IDLE, including in DONE.
  - `stage_done` outside RUN.
  - `load_done` outside WAIT_LOAD.
- `stage` arithmetic: SIZE-bit unsigned, never wraps; the advance step guards it at SIZE-1.
- `rst` takes priority over every other input in every state. It aborts a frame in progress, and all outputs return to their reset values at that edge.

## Timing
- `start` sampled at edge k → WAIT_LOAD in cycle k+1. If `load_done` is already high, `start_stage` is high in cycle k+2.
- Pipelined launches: if `start_stage` is high in cycle t and `stage_done` is high in cycle t+d (d≥1), the next `start_stage` is high in cycle t+d+PIPE_LAT+1.
- End of frame: `frame_done` is high in cycle t_last+d+PIPE_LAT+1, and `busy` drops in the following cycle.
- A new `start` is accepted no earlier than the cycle after `frame_done`.
- `start_stage` and `frame_done` are never high in the same cycle and are never high for 2 consecutive cycles.

## Configuration
- `FFT_SCHED_WDOG_EN` defined:
  - A counter runs while in RUN and clears on entry to RUN.
  - If it reaches TIMEOUT with no `stage_done`, `err` is set and the state goes to IDLE. No `frame_done` is issued.
  - `err` is sticky until `rst`, or until the next accepted `start`, which clears it.
- `FFT_SCHED_WDOG_EN` undefined: no counter is built, `err` is constant 0, and RUN waits indefinitely.

## Test plan
- N=16, PIPE_LAT=3, `load_done` held 1, `start` at cycle 0, `stage_done` 8 cycles after each `start_stage` → `start_stage` in cycles 2, 14, 26, 38; `stage`=0,1,2,3; `tw_shift`=3,2,1,0; `bank_sel`=0,1,0,1; `frame_done` in cycle 50; `busy` low from cycle 51.
- `load_done` held 0 for 20 cycles after `start` → no `start_stage` and `busy`=1 throughout. Raising `load_done` gives `start_stage` exactly 1 cycle later.
- `start` and spurious `stage_done` pulses during RUN/DRAIN/DONE, and `stage_done` in IDLE → no state change, no extra `start_stage`, stage sequence identical to test 1.
- `rst` asserted in the 2nd RUN → next cycle all outputs are at reset values. A subsequent `start` restarts from `stage`=0, `bank_sel`=0.
- PIPE_LAT=0, `stage_done` 1 cycle after each `start_stage` → `start_stage` every 2 cycles, 4 pulses, then `frame_done`.
- With `FFT_SCHED_WDOG_EN` and TIMEOUT=64, `stage_done` withheld in stage 1 → `err`=1 after 64 RUN cycles, state returns to IDLE, no `frame_done`. Without the macro, the block stays in RUN and `err`=0.
